// File: rtl/mlp_regs_pkg.sv
// Shared register-map constants, CTRL bit positions and front-end state encoding
// for the MLP host register front end.
package mlp_regs_pkg;

    localparam logic [1:0] CTRL_ADDR        = 2'd0;
    localparam logic [1:0] INPUT_FIFO_ADDR  = 2'd1;
    localparam logic [1:0] WEIGHT_FIFO_ADDR = 2'd2;
    localparam logic [1:0] OUTPUT_REG_ADDR  = 2'd3;

    localparam int CTRL_RUN       = 0;
    localparam int CTRL_DONE      = 1;
    localparam int CTRL_BUSY      = 2;
    localparam int CTRL_LAYER_SEL = 3;
    localparam int CTRL_ERR       = 4;
    localparam int CTRL_IE        = 5;
    localparam int CTRL_PTR_CLR   = 6;

    typedef enum logic [1:0] {
        FE_IDLE  = 2'd0,
        FE_START = 2'd1,
        FE_BUSY  = 2'd2
    } fe_state_t;

endpackage

// File: rtl/mlp_wbuf.sv
// Write-pointer register buffer: sequential writes with wrapping pointer,
// saturating fill count, synchronous pointer clear and a combinational read port.
module mlp_wbuf #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 16,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        we,
    input  logic [WIDTH-1:0]            wdata,
    input  logic [AW-1:0]               raddr,
    output logic [WIDTH-1:0]            rdata,
    output logic [DEPTH-1:0][WIDTH-1:0] contents,
    output logic [7:0]                  count
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               ptr;
    logic [CW-1:0]               cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem <= '0;
            ptr <= '0;
            cnt <= '0;
        end else if (clr) begin
            // contents survive a clear; only the fill state restarts
            ptr <= '0;
            cnt <= '0;
        end else if (we) begin
            mem[ptr] <= wdata;
            ptr      <= (int'(ptr) == DEPTH - 1) ? '0 : ptr + 1'b1;
            if (int'(cnt) != DEPTH)
                cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        rdata = '0;
        if (int'(raddr) < DEPTH)
            rdata = mem[raddr];
    end

    assign contents = mem;
    assign count    = 8'(cnt);

endmodule

// File: rtl/mlp_reg_frontend.sv
// Host register front end for the MLP core: decodes CTRL/FIFO writes into three
// buffers, sequences start/done with the core and returns registered readdata and irq.
module mlp_reg_frontend
    import mlp_regs_pkg::*;
#(
    parameter int N_INPUTS  = 2,
    parameter int N_HIDDEN  = 4,
    parameter int N_OUTPUT  = 1,
    parameter int IN_WIDTH  = 16,
    parameter int WGT_WIDTH = 16,
    parameter int OUT_WIDTH = 16
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       write_en,
    input  logic [1:0]                                 addr,
    input  logic [31:0]                                writedata,
    output logic [31:0]                                readdata,
    output logic                                       irq,
    output logic                                       core_start,
    input  logic                                       core_done,
    input  logic [OUT_WIDTH*N_OUTPUT-1:0]              core_result,
    output logic [N_INPUTS*IN_WIDTH-1:0]               in_vec,
    input  logic [$clog2(N_HIDDEN*(N_INPUTS+1))-1:0]   hw_raddr,
    output logic [WGT_WIDTH-1:0]                       hw_rdata,
    input  logic [$clog2(N_OUTPUT*(N_HIDDEN+1))-1:0]   ow_raddr,
    output logic [WGT_WIDTH-1:0]                       ow_rdata
);

    localparam int HW_DEPTH = N_HIDDEN * (N_INPUTS + 1);
    localparam int OW_DEPTH = N_OUTPUT * (N_HIDDEN + 1);
    localparam int IN_AW    = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

    fe_state_t state, state_nx;

    logic done, err, layer_sel, ie;
    logic [OUT_WIDTH*N_OUTPUT-1:0] result;
    logic [7:0] in_cnt, hw_cnt, ow_cnt;

    logic busy, wr_ctrl, run_req, start_ok, clr_ptrs, fifo_wr;
    logic in_we, hw_we, ow_we, done_accept;

    assign busy        = (state != FE_IDLE);
    assign wr_ctrl     = write_en && (addr == CTRL_ADDR);
    assign run_req     = wr_ctrl && writedata[CTRL_RUN];
    assign start_ok    = run_req && !busy;
    assign clr_ptrs    = start_ok || (wr_ctrl && writedata[CTRL_PTR_CLR] && !busy);
    assign fifo_wr     = write_en && (addr == INPUT_FIFO_ADDR || addr == WEIGHT_FIFO_ADDR);
    assign in_we       = write_en && (addr == INPUT_FIFO_ADDR) && !busy;
    assign hw_we       = write_en && (addr == WEIGHT_FIFO_ADDR) && !layer_sel && !busy;
    assign ow_we       = write_en && (addr == WEIGHT_FIFO_ADDR) &&  layer_sel && !busy;
    assign done_accept = core_done && busy;

    logic [N_INPUTS-1:0][IN_WIDTH-1:0]  in_contents;
    logic [HW_DEPTH-1:0][WGT_WIDTH-1:0] hw_contents_unused;
    logic [OW_DEPTH-1:0][WGT_WIDTH-1:0] ow_contents_unused;
    logic [IN_WIDTH-1:0]                in_rdata_unused;

    mlp_wbuf #(.DEPTH(N_INPUTS), .WIDTH(IN_WIDTH)) u_in_buf (
        .clk(clk), .rst(rst), .clr(clr_ptrs), .we(in_we),
        .wdata(writedata[IN_WIDTH-1:0]), .raddr(IN_AW'(0)), .rdata(in_rdata_unused),
        .contents(in_contents), .count(in_cnt)
    );

    mlp_wbuf #(.DEPTH(HW_DEPTH), .WIDTH(WGT_WIDTH)) u_hw_buf (
        .clk(clk), .rst(rst), .clr(clr_ptrs), .we(hw_we),
        .wdata(writedata[WGT_WIDTH-1:0]), .raddr(hw_raddr), .rdata(hw_rdata),
        .contents(hw_contents_unused), .count(hw_cnt)
    );

    mlp_wbuf #(.DEPTH(OW_DEPTH), .WIDTH(WGT_WIDTH)) u_ow_buf (
        .clk(clk), .rst(rst), .clr(clr_ptrs), .we(ow_we),
        .wdata(writedata[WGT_WIDTH-1:0]), .raddr(ow_raddr), .rdata(ow_rdata),
        .contents(ow_contents_unused), .count(ow_cnt)
    );

    assign in_vec = in_contents;

    always_ff @(posedge clk) begin
        if (!rst) state <= FE_IDLE;
        else      state <= state_nx;
    end

    // core_done in START is accepted too, so a very fast core is never missed
    always_comb begin
        state_nx   = state;
        core_start = 1'b0;
        case (state)
            FE_IDLE:  if (start_ok) state_nx = FE_START;
            FE_START: begin
                core_start = 1'b1;
                state_nx   = core_done ? FE_IDLE : FE_BUSY;
            end
            FE_BUSY:  if (core_done) state_nx = FE_IDLE;
            default:  state_nx = FE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            done      <= 1'b0;
            err       <= 1'b0;
            layer_sel <= 1'b0;
            ie        <= 1'b0;
            result    <= '0;
        end else begin
            if (wr_ctrl) begin
                layer_sel <= writedata[CTRL_LAYER_SEL];
                ie        <= writedata[CTRL_IE];
            end
            // status sets take priority over a same-cycle write-one-to-clear
            if (done_accept)
                done <= 1'b1;
            else if (start_ok || (wr_ctrl && writedata[CTRL_DONE]))
                done <= 1'b0;
            if (busy && (run_req || fifo_wr))
                err <= 1'b1;
            else if (wr_ctrl && writedata[CTRL_ERR])
                err <= 1'b0;
            if (done_accept)
                result <= core_result;
        end
    end

    logic [31:0] ctrl_word, rd_mux;

    always_comb begin
        ctrl_word                 = '0;
        ctrl_word[CTRL_DONE]      = done;
        ctrl_word[CTRL_BUSY]      = busy;
        ctrl_word[CTRL_LAYER_SEL] = layer_sel;
        ctrl_word[CTRL_ERR]       = err;
        ctrl_word[CTRL_IE]        = ie;
        ctrl_word[15:8]           = in_cnt;
        ctrl_word[23:16]          = hw_cnt;
        ctrl_word[31:24]          = ow_cnt;
    end

    always_comb begin
        rd_mux = '0;
        case (addr)
            CTRL_ADDR:       rd_mux = ctrl_word;
            OUTPUT_REG_ADDR: rd_mux = {{(32-OUT_WIDTH){result[OUT_WIDTH-1]}}, result[OUT_WIDTH-1:0]};
            default:         rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) readdata <= '0;
        else      readdata <= rd_mux;
    end

    assign irq = done & ie;

    logic bits_unused;
    assign bits_unused = ^{writedata, result};

endmodule

// File: tb/tb_mlp_reg_frontend.sv
// Directed bench for mlp_reg_frontend: stimulus pushes expected observations into
// a scoreboard queue tagged with the cycle they are due; a monitor compares them.
module tb_mlp_reg_frontend;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        write_en = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        irq, core_start;
    logic        core_done = 1'b0;
    logic [15:0] core_result = '0;
    logic [31:0] in_vec;
    logic [3:0]  hw_raddr = '0;
    logic [15:0] hw_rdata;
    logic [2:0]  ow_raddr = '0;
    logic [15:0] ow_rdata;

    mlp_reg_frontend dut (
        .clk(clk), .rst(rst), .write_en(write_en), .addr(addr), .writedata(writedata),
        .readdata(readdata), .irq(irq), .core_start(core_start), .core_done(core_done),
        .core_result(core_result), .in_vec(in_vec), .hw_raddr(hw_raddr), .hw_rdata(hw_rdata),
        .ow_raddr(ow_raddr), .ow_rdata(ow_rdata)
    );

    always #5 clk = ~clk;

    localparam int K_RD = 0, K_INVEC = 1, K_IRQ = 2, K_CST = 3, K_HW = 4, K_OW = 5;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
        int          due;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] observe(int kind);
        case (kind)
            K_RD:    return readdata;
            K_INVEC: return in_vec;
            K_IRQ:   return 32'(irq);
            K_CST:   return 32'(core_start);
            K_HW:    return 32'(hw_rdata);
            default: return 32'(ow_rdata);
        endcase
    endfunction

    // monitor: compare every expectation that has come due this cycle
    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].due <= cyc) begin
                logic [31:0] got;
                got = observe(q[i].kind);
                checks++;
                if (got !== q[i].exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h (cycle %0d)", q[i].name, got, q[i].exp, cyc);
                end
                q.delete(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        write_en  = 1'b1;
        addr      = a;
        writedata = d;
        tick();
        write_en  = 1'b0;
    endtask

    // readdata is registered: the value for addr appears after the next edge
    task automatic rd(input logic [1:0] a, input string name, input logic [31:0] e);
        write_en = 1'b0;
        addr     = a;
        q.push_back('{name, K_RD, e, cyc + 1});
        tick();
    endtask

    task automatic chk(input int kind, input string name, input logic [31:0] e);
        q.push_back('{name, kind, e, cyc});
        @(negedge clk);
        #1;
    endtask

    initial begin
        // reset
        rst = 1'b0;
        tick(); tick();
        chk(K_RD, "rst_readdata", 32'h0);
        chk(K_IRQ, "rst_irq", 32'h0);
        chk(K_INVEC, "rst_in_vec", 32'h0);
        chk(K_CST, "rst_core_start", 32'h0);
        rst = 1'b1;
        rd(2'd0, "rst_ctrl", 32'h0);

        // load buffers
        wr(2'd1, 32'h0000_FF00);
        wr(2'd1, 32'h0000_0200);
        chk(K_INVEC, "load_in_vec", 32'h0200_FF00);
        for (int i = 0; i < 12; i++) wr(2'd2, 32'h100 + i);
        wr(2'd0, 32'h08);
        for (int j = 0; j < 5; j++) wr(2'd2, 32'h200 + j);
        hw_raddr = 4'd3;
        chk(K_HW, "load_hw3", 32'h103);
        ow_raddr = 3'd4;
        chk(K_OW, "load_ow4", 32'h204);
        rd(2'd0, "load_counts", 32'h050C_0208);

        // run
        wr(2'd0, 32'h29);
        chk(K_CST, "run_start_pulse", 32'h1);
        rd(2'd0, "run_busy", 32'h0000_002C);
        chk(K_CST, "run_start_low", 32'h0);

        // errors while busy
        wr(2'd0, 32'h29);
        chk(K_CST, "busy_no_restart", 32'h0);
        wr(2'd1, 32'h1234);
        chk(K_INVEC, "busy_in_vec_kept", 32'h0200_FF00);
        rd(2'd0, "busy_err", 32'h0000_003C);

        // core completes
        core_done = 1'b1; core_result = 16'hFE80;
        tick();
        core_done = 1'b0;
        chk(K_IRQ, "done_irq", 32'h1);
        rd(2'd0, "done_ctrl", 32'h0000_003A);
        rd(2'd3, "done_output", 32'hFFFF_FE80);

        // W1C clears DONE and ERR
        wr(2'd0, 32'h12);
        chk(K_IRQ, "w1c_irq", 32'h0);
        rd(2'd0, "w1c_ctrl", 32'h0);

        // pointer wrap and count saturation
        wr(2'd1, 32'd1); wr(2'd1, 32'd2); wr(2'd1, 32'd3);
        chk(K_INVEC, "wrap_in_vec", 32'h0002_0003);
        for (int i = 0; i < 13; i++) wr(2'd2, 32'h300 + i);
        hw_raddr = 4'd0;
        chk(K_HW, "wrap_hw0", 32'h30C);
        hw_raddr = 4'd1;
        chk(K_HW, "wrap_hw1", 32'h301);
        rd(2'd0, "wrap_counts", 32'h000C_0200);

        // PTR_CLR, idle core_done, ignored write to OUTPUT, zero reads of FIFOs
        wr(2'd0, 32'h40);
        rd(2'd0, "ptrclr_ctrl", 32'h0);
        core_done = 1'b1; core_result = 16'h1234;
        tick();
        core_done = 1'b0;
        rd(2'd3, "idle_done_output", 32'hFFFF_FE80);
        rd(2'd0, "idle_done_ctrl", 32'h0);
        wr(2'd3, 32'h5555);
        rd(2'd3, "out_write_ignored", 32'hFFFF_FE80);
        rd(2'd1, "read_input_addr", 32'h0);
        rd(2'd2, "read_weight_addr", 32'h0);

        // core_done and DONE W1C in the same cycle: set wins
        wr(2'd0, 32'h21);
        tick();
        core_done = 1'b1; core_result = 16'h0042;
        write_en = 1'b1; addr = 2'd0; writedata = 32'h22;
        tick();
        write_en = 1'b0; core_done = 1'b0;
        chk(K_IRQ, "done_beats_w1c_irq", 32'h1);
        rd(2'd0, "done_beats_w1c_ctrl", 32'h0000_0022);
        rd(2'd3, "done_beats_w1c_out", 32'h0000_0042);
        wr(2'd0, 32'h02);

        // reset mid-run, then a late core_done
        wr(2'd0, 32'h01);
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        core_done = 1'b1; core_result = 16'h7777;
        tick();
        core_done = 1'b0;
        rd(2'd0, "midrst_ctrl", 32'h0);
        rd(2'd3, "midrst_output", 32'h0);
        chk(K_INVEC, "midrst_in_vec", 32'h0);
        chk(K_IRQ, "midrst_irq", 32'h0);

        tick(); tick();
        if (q.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
            errors += q.size();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
